// File: rtl/byte_thresholding_pkg.sv
// Shared defaults and types for the byte thresholding comparator.
//   WIDTH       : sample / output width
//   DEFAULT_THR : threshold used until the first calibration sample
//   ON_VALUE    : output code for "pixel on" (must be non-zero)
//   sample_t    : one pixel sample
package byte_thresholding_pkg;

  localparam int              WIDTH       = 8;
  localparam logic [WIDTH-1:0] DEFAULT_THR = 8'h80;
  localparam logic [WIDTH-1:0] ON_VALUE    = 8'hFF;

  typedef logic [WIDTH-1:0] sample_t;

endpackage

// File: rtl/byte_thresholding_minmax_tracker.sv
// Running min/max of calibration samples plus their rounded midpoint.
//   clk, rst_n : clock, async active-low reset
//   load_i     : first calibration cycle, restart min/max from sample_i
//   update_i   : calibration cycle, fold sample_i into min/max
//   sample_i   : incoming byte
//   mid_o      : (new_min + new_max + 1) >> 1, from this cycle's updated values
module byte_thresholding_minmax_tracker
  import byte_thresholding_pkg::*;
#(
  parameter int WIDTH = byte_thresholding_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             update_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] mid_o
);

  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (load_i) begin
      min_d = sample_i;
      max_d = sample_i;
    end else if (update_i) begin
      min_d = (sample_i < min_q) ? sample_i : min_q;
      max_d = (sample_i > max_q) ? sample_i : max_q;
    end
  end

  // One extra bit holds the carry, so the midpoint of FF/FF stays FF.
  assign sum   = {1'b0, min_d} + {1'b0, max_d} + {{WIDTH{1'b0}}, 1'b1};
  assign mid_o = WIDTH'(sum >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

endmodule

// File: rtl/byte_thresholding.sv
// Binarising comparator for the pixel stream. mode=1 calibrates the threshold
// from the min/max of incoming bytes; mode=0 emits ON_VALUE or 0 per byte,
// one cycle later, with an optional hysteresis hold band.
//   clk, rst_n : clock, async active-low reset
//   mode       : 1 = calibrate, 0 = run
//   ip_byte    : sample, valid every cycle
//   t_op       : registered result, ON_VALUE or 0
module byte_thresholding
  import byte_thresholding_pkg::*;
#(
  parameter int               WIDTH       = byte_thresholding_pkg::WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_THR = byte_thresholding_pkg::DEFAULT_THR,
  parameter int               HYST        = 0,
  parameter logic [WIDTH-1:0] ON_VALUE    = byte_thresholding_pkg::ON_VALUE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [WIDTH-1:0] ip_byte,
  output logic [WIDTH-1:0] t_op
);

  localparam logic [WIDTH:0] HYST_W = (WIDTH+1)'(HYST);

  logic             mode_q;
  logic             cal_valid_q;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic [WIDTH-1:0] t_op_q, t_op_d;
  logic [WIDTH-1:0] mid;
  logic [WIDTH-1:0] thr_eff;
  logic [WIDTH:0]   hi_sum, lo_diff;
  logic [WIDTH-1:0] thr_hi, thr_lo;
  logic             cal_entry;

  assign cal_entry = mode & ~mode_q;

  byte_thresholding_minmax_tracker #(.WIDTH(WIDTH)) u_minmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (cal_entry),
    .update_i (mode),
    .sample_i (ip_byte),
    .mid_o    (mid)
  );

  assign thr_eff = cal_valid_q ? thr_q : DEFAULT_THR;

  // Bounds are formed with a spare top bit: a carry saturates high,
  // a borrow saturates low.
  assign hi_sum  = {1'b0, thr_eff} + HYST_W;
  assign lo_diff = {1'b0, thr_eff} - HYST_W;
  assign thr_hi  = hi_sum[WIDTH]  ? '1 : hi_sum[WIDTH-1:0];
  assign thr_lo  = lo_diff[WIDTH] ? '0 : lo_diff[WIDTH-1:0];

  always_comb begin
    thr_d  = thr_q;
    t_op_d = t_op_q;
    if (mode) begin
      thr_d  = mid;
      t_op_d = '0;
    end else if (ip_byte >= thr_hi) begin
      t_op_d = ON_VALUE;
    end else if (ip_byte < thr_lo) begin
      t_op_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      cal_valid_q <= 1'b0;
      thr_q       <= DEFAULT_THR;
      t_op_q      <= '0;
    end else begin
      mode_q      <= mode;
      cal_valid_q <= cal_valid_q | mode;
      thr_q       <= thr_d;
      t_op_q      <= t_op_d;
    end
  end

  assign t_op = t_op_q;

endmodule

// File: tb/tb_byte_thresholding.sv
module tb_byte_thresholding;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [7:0] ip_byte;
  logic [7:0] t_op0, t_op4;

  int errors = 0;
  int checks = 0;

  logic [7:0] q0[$];
  logic [7:0] q4[$];

  // reference state, index 0: HYST=0, index 1: HYST=4
  int  hyst_tab[2] = '{0, 4};
  int  m_lo[2], m_hi[2], m_thr[2], m_out[2];
  bit  m_valid[2], m_prev[2];

  always #5 clk = ~clk;

  byte_thresholding #(.HYST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ip_byte(ip_byte), .t_op(t_op0));

  byte_thresholding #(.HYST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ip_byte(ip_byte), .t_op(t_op4));

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lo[k] = 255; m_hi[k] = 0; m_thr[k] = 128; m_out[k] = 0;
      m_valid[k] = 0; m_prev[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit m, input int b);
    int t, up, dn;
    if (m) begin
      if (!m_prev[k]) begin
        m_lo[k] = b; m_hi[k] = b;
      end else begin
        if (b < m_lo[k]) m_lo[k] = b;
        if (b > m_hi[k]) m_hi[k] = b;
      end
      m_thr[k]   = (m_lo[k] + m_hi[k] + 1) / 2;
      m_valid[k] = 1;
      m_out[k]   = 0;
    end else begin
      t  = m_valid[k] ? m_thr[k] : 128;
      up = t + hyst_tab[k]; if (up > 255) up = 255;
      dn = t - hyst_tab[k]; if (dn < 0) dn = 0;
      if (b >= up)     m_out[k] = 255;
      else if (b < dn) m_out[k] = 0;
    end
    m_prev[k] = m;
  endtask

  task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] obs, input bit which);
    if (which == 0 && q0.size() > 0) compare(tag, obs, q0.pop_front());
    else if (which == 1 && q4.size() > 0) compare(tag, obs, q4.pop_front());
    else begin
      checks++; errors++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end
  endtask

  // e0/e4 >= 0 pin the expectation to a hand-derived value instead of the model.
  task automatic step(input string tag, input bit m, input logic [7:0] b,
                      input int e0 = -1, input int e4 = -1);
    @(negedge clk);
    mode = m; ip_byte = b;
    model_step(0, m, int'(b));
    model_step(1, m, int'(b));
    q0.push_back(e0 >= 0 ? 8'(e0) : 8'(m_out[0]));
    q4.push_back(e4 >= 0 ? 8'(e4) : 8'(m_out[1]));
    @(posedge clk); #1;
    pop_check({tag, "/h0"}, t_op0, 1'b0);
    pop_check({tag, "/h4"}, t_op4, 1'b1);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    compare({tag, "/h0"}, t_op0, 8'h00);
    compare({tag, "/h4"}, t_op4, 8'h00);
    model_reset();
    @(negedge clk);
    mode = 1'b0; ip_byte = 8'h00;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; ip_byte = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare("reset_t_op/h0", t_op0, 8'h00);
    compare("reset_t_op/h4", t_op4, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // single-sample calibration, threshold 0F
    step("cal0f",     1'b1, 8'h0F, 8'h00, 8'h00);
    step("run10",     1'b0, 8'h10, 8'hFF, -1);
    step("run0e",     1'b0, 8'h0E, 8'h00, -1);
    step("run0f",     1'b0, 8'h0F, 8'hFF, -1);

    // three-sample calibration, threshold 60
    step("cal20",     1'b1, 8'h20, 8'h00, 8'h00);
    step("cala0",     1'b1, 8'hA0, 8'h00, 8'h00);
    step("cal60",     1'b1, 8'h60, 8'h00, 8'h00);
    step("run5f",     1'b0, 8'h5F, 8'h00, -1);
    step("run60",     1'b0, 8'h60, 8'hFF, -1);

    // default threshold and hysteresis band around 80
    apply_reset("rst_after_run");
    step("def7e",     1'b0, 8'h7E, 8'h00, 8'h00);
    step("def84",     1'b0, 8'h84, 8'hFF, 8'hFF);
    step("def7d",     1'b0, 8'h7D, 8'h00, 8'hFF);
    step("def7b",     1'b0, 8'h7B, 8'h00, 8'h00);
    step("def7f",     1'b0, 8'h7F, 8'h00, 8'h00);
    step("def80",     1'b0, 8'h80, 8'hFF, -1);

    // second calibration must forget the first one's max
    step("calf0",     1'b1, 8'hF0);
    step("runf0",     1'b0, 8'hF0, 8'hFF, -1);
    step("recal10a",  1'b1, 8'h10);
    step("recal10b",  1'b1, 8'h10);
    step("run0f_b",   1'b0, 8'h0F, 8'h00, 8'h00);
    step("run10_b",   1'b0, 8'h10, 8'hFF, -1);

    // all-FF calibration
    step("calff_a",   1'b1, 8'hFF);
    step("calff_b",   1'b1, 8'hFF);
    step("runff",     1'b0, 8'hFF, 8'hFF, 8'hFF);
    step("runfe",     1'b0, 8'hFE, 8'h00, -1);

    // all-00 calibration; with HYST=4 the low bound saturates at 0
    step("cal00_a",   1'b1, 8'h00);
    step("cal00_b",   1'b1, 8'h00);
    step("run00",     1'b0, 8'h00, 8'hFF, 8'h00);
    step("run05",     1'b0, 8'h05, 8'hFF, 8'hFF);
    step("run00_b",   1'b0, 8'h00, 8'hFF, 8'hFF);

    // mode toggling every cycle restarts min/max at each entry
    step("tog_c40",   1'b1, 8'h40);
    step("tog_r40",   1'b0, 8'h40, 8'hFF, -1);
    step("tog_c20",   1'b1, 8'h20);
    step("tog_r1f",   1'b0, 8'h1F, 8'h00, -1);
    step("tog_c90",   1'b1, 8'h90);
    step("tog_r8f",   1'b0, 8'h8F, 8'h00, -1);

    // reset mid-calibration, then mid-run with output high
    step("mc_cal30",  1'b1, 8'h30);
    apply_reset("rst_mid_cal");
    step("mr_runa0",  1'b0, 8'hA0, 8'hFF, 8'hFF);
    apply_reset("rst_mid_run");
    step("post7f",    1'b0, 8'h7F, 8'h00, 8'h00);
    step("post80",    1'b0, 8'h80, 8'hFF, -1);

    // randomised stream against the reference model
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
